// File: rtl/dccm_ctrl.sv
// DCCM controller: word-organised SRAM behind the load/store unit's MEM-stage port.
// Byte-lane stores, one-cycle registered loads with write-first bypass, sticky error capture.
module dccm_ctrl #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  wr_size_i,
  input  logic        rd_en_i,
  input  logic [31:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        misalign_o,
  output logic        range_err_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  size_e         wr_size;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_oor;
  logic          rd_oor;
  logic          wr_mis;
  logic          wr_bad;
  logic          rd_bad;
  logic          wr_commit;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lanes;
  logic [31:0]   rd_word;
  logic          new_err;
  logic [31:0]   new_err_addr;
  logic          rd_addr_unused;

  assign wr_size        = size_e'(wr_size_i);
  assign wr_idx         = wr_addr_i[AW+1:2];
  assign rd_idx         = rd_addr_i[AW+1:2];
  assign wr_oor         = |wr_addr_i[31:AW+2];
  assign rd_oor         = |rd_addr_i[31:AW+2];
  assign rd_addr_unused = ^rd_addr_i[1:0];

  // Lane replication lets the byte enables alone pick where the data lands.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = 32'h0;
    wr_mis   = 1'b0;
    case (wr_size)
      SZ_BYTE: begin
        wr_be    = 4'b0001 << wr_addr_i[1:0];
        wr_lanes = {4{wr_data_i[7:0]}};
      end
      SZ_HALF: begin
        wr_be    = wr_addr_i[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_data_i[15:0]}};
        wr_mis   = wr_addr_i[0];
      end
      SZ_WORD: begin
        wr_be    = 4'b1111;
        wr_lanes = wr_data_i;
        wr_mis   = |wr_addr_i[1:0];
      end
      default: wr_mis = 1'b1;
    endcase
  end

  assign wr_bad    = wr_en_i & (wr_mis | wr_oor);
  assign rd_bad    = rd_en_i & rd_oor;
  assign wr_commit = wr_en_i & ~wr_mis & ~wr_oor;

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array carries no reset; only the registered outputs are reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Same-word store in this cycle overrides the stale array lanes (write-first).
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_commit && (wr_idx == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wr_lanes[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o  <= 32'h0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_oor ? 32'h0 : rd_word;
    end
  end

  assign new_err      = wr_bad | rd_bad;
  assign new_err_addr = wr_bad ? wr_addr_i : rd_addr_i;

  // A clear in the same cycle as a new error still captures that error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o  <= 1'b0;
      range_err_o <= 1'b0;
      err_addr_o  <= 32'h0;
    end else if (err_clr_i) begin
      misalign_o  <= wr_en_i & wr_mis;
      range_err_o <= (wr_en_i & wr_oor) | rd_bad;
      err_addr_o  <= new_err ? new_err_addr : 32'h0;
    end else begin
      misalign_o  <= misalign_o | (wr_en_i & wr_mis);
      range_err_o <= range_err_o | (wr_en_i & wr_oor) | rd_bad;
      if (new_err && !misalign_o && !range_err_o) err_addr_o <= new_err_addr;
    end
  end

endmodule

// File: tb/tb_dccm_ctrl.sv
// Directed bench for dccm_ctrl: loads push expected words into a scoreboard queue,
// a negedge monitor pops and compares whenever rd_valid_o is seen.
module tb_dccm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  wr_size = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        misalign;
  logic        range_err;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dccm_ctrl #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_size_i  (wr_size),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .misalign_o (misalign),
    .range_err_o(range_err),
    .err_addr_o (err_addr),
    .err_clr_i  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid load result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got valid data %h expected no load", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_size = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic store_load(input logic [31:0] wa, input logic [31:0] d, input logic [1:0] s,
                            input logic [31:0] ra, input logic [31:0] exp);
    wr_en = 1'b1; wr_addr = wa; wr_data = d; wr_size = s;
    rd_en = 1'b1; rd_addr = ra;
    exp_q.push_back(exp);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_err(input string tag, input logic m, input logic r, input logic [31:0] a);
    check({tag, "_misalign"}, {31'h0, misalign}, {31'h0, m});
    check({tag, "_range"}, {31'h0, range_err}, {31'h0, r});
    check({tag, "_err_addr"}, err_addr, a);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check_err("rst", 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();

    // Word write then read, back-to-back
    store(32'h10, 32'hDEADBEEF, 2'b10);
    load(32'h10, 32'hDEADBEEF);

    // Byte/half merge into the low and high halves
    store(32'h0, 32'h11223344, 2'b10);
    store(32'h2, 32'h000000AA, 2'b00);
    store(32'h0, 32'h00005566, 2'b01);
    load(32'h0, 32'h11AA5566);
    store(32'h4, 32'h0, 2'b10);
    store(32'h6, 32'h0000BEEF, 2'b01);
    store(32'h5, 32'h00000012, 2'b00);
    load(32'h4, 32'hBEEF1200);
    check_err("merge", 1'b0, 1'b0, 32'h0);

    // Misaligned stores are suppressed; first address is held
    store(32'h20, 32'h12345678, 2'b10);
    store(32'h40, 32'hCAFEF00D, 2'b10);
    store(32'h21, 32'hFFFFFFFF, 2'b10);
    check_err("mis1", 1'b1, 1'b0, 32'h21);
    load(32'h20, 32'h12345678);
    store(32'h42, 32'hFFFFFFFF, 2'b10);
    check_err("mis2", 1'b1, 1'b0, 32'h21);
    store(32'h40, 32'h11111111, 2'b11);
    load(32'h40, 32'hCAFEF00D);
    clear_err();
    check_err("clr1", 1'b0, 1'b0, 32'h0);

    // Out-of-range load and store; no aliasing into word 0
    load(32'h1000, 32'h0);
    check_err("rng_ld", 1'b0, 1'b1, 32'h1000);
    store(32'h1000, 32'hFFFFFFFF, 2'b10);
    load(32'h0, 32'h11AA5566);
    check_err("rng_st", 1'b0, 1'b1, 32'h1000);

    // Clear coinciding with a new error: the new error wins
    err_clr = 1'b1;
    store(32'h31, 32'h0000ABCD, 2'b01);
    err_clr = 1'b0;
    check_err("clr_new", 1'b1, 1'b0, 32'h31);
    clear_err();

    // Store and load errors in one cycle: store address captured, both flags set
    store_load(32'h23, 32'h0, 2'b10, 32'h4000, 32'h0);
    check_err("dual", 1'b1, 1'b1, 32'h23);
    clear_err();

    // Same-word collision returns the post-write word
    store(32'h8, 32'h0, 2'b10);
    store_load(32'h9, 32'h0000007F, 2'b00, 32'h8, 32'h00007F00);
    load(32'h8, 32'h00007F00);
    tick();
    check("hold_valid", {31'h0, rd_valid}, 32'h0);
    check("hold_data", rd_data, 32'h00007F00);

    // Reset during a pending load clears outputs and keeps the array
    load(32'h1000, 32'h0);
    rd_en = 1'b1; rd_addr = 32'h10;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_mid_data", rd_data, 32'h0);
    check_err("rst_mid", 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", {31'h0, rd_valid}, 32'h0);
    load(32'h10, 32'hDEADBEEF);
    load(32'h0, 32'h11AA5566);

    tick();
    tick();
    check("pending_loads", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dccm_ctrl.md
# dccm_ctrl

Data closely-coupled memory (DCCM) controller: the storage behind the load/store unit's DCCM port in the MEM stage. It has a word-organised SRAM array with byte-lane store alignment derived from the store size, and a one-cycle registered read. It also provides write-first bypass on same-word read/write collisions and sticky error capture for misaligned or out-of-range stores. Loads return the full aligned word; sub-word extraction and sign extension stay in the load/store unit.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥4.
- AW, $clog2(DEPTH_WORDS), word-index width; derived, do not override.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en_i  input  1  store request this cycle.
- wr_addr_i  input  32  store byte address.
- wr_data_i  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- wr_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- rd_en_i  input  1  load request this cycle.
- rd_addr_i  input  32  load byte address; bits [1:0] ignored.
- rd_data_o  output  32  aligned word read; registered.
- rd_valid_o  output  1  rd_data_o updated from a load issued last cycle.
- misalign_o  output  1  sticky: a store was misaligned or had an illegal size.
- range_err_o  output  1  sticky: an access fell outside the array.
- err_addr_o  output  32  address of the first captured error.
- err_clr_i  input  1  clears all sticky error state.

## Operation
- Word index is addr[AW+1:2]. An address is out of range when addr[31:AW+2] != 0.
- Byte enables for stores:
  - Byte: be = 4'b0001 << addr[1:0]; data placed in lane addr[1:0].
  - Half: addr[1]=0 gives be=0011 with data in [15:0]; addr[1]=1 gives be=1100 with data in [31:16].
  - Word: be=1111.
- A store is misaligned when it is a half with addr[0]=1, a word with addr[1:0]!=0, or size 11. A misaligned or out-of-range store is suppressed: the array is unchanged and the error is flagged.
- Only enabled lanes of the addressed word are written. Other lanes are preserved.
- Loads:
  - An in-range load registers array[idx] into rd_data_o.
  - An out-of-range load registers 0 and flags range_err.
  - Loads never flag misalign.
- Collision: when an in-range store and a load hit the same word in the same cycle, the load returns the post-write word (write-first, per lane).
- When rd_en_i=0, rd_data_o holds its previous value.
- Error capture:
  - Flags are sticky until err_clr_i.
  - err_addr_o is loaded only when no flag is currently set, so it holds the first error.
  - If store and load errors occur in the same cycle, err_addr_o takes the store address and both relevant flags set.
  - err_clr_i together with a new error in the same cycle: the new error wins, so the flags set and err_addr_o loads the new address.
- Array contents are not reset. Behaviour is defined only for words written since power-up.

## Timing
- Reset values: rd_data_o=0, rd_valid_o=0, misalign_o=0, range_err_o=0, err_addr_o=0.
- Load latency is 1 cycle. A request in cycle N gives rd_data_o and rd_valid_o=1 in cycle N+1. rd_valid_o is 0 in any cycle after rd_en_i=0.
- Store commits at the end of cycle N. A load in cycle N+1 to the same word sees the new data without bypass.
- Error flags assert in the cycle after the offending request.
- Back-to-back loads and stores are accepted every cycle; there is no stall or backpressure.
- Reset asserted mid-operation clears all registered outputs immediately. A pending load's rd_valid_o does not appear after reset release. Array contents are retained.

## Test plan
- Word write then read:
  - Store 0xDEADBEEF to 0x10 (size 10).
  - Load 0x10 next cycle: rd_data_o=0xDEADBEEF, rd_valid_o=1 one cycle after rd_en_i.
- Byte/half merge:
  - Word 0x0 = 0x11223344; store byte 0xAA to 0x2, then half 0x5566 to 0x0.
  - Load 0x0 gives 0x11AA5566.
- Misaligned store:
  - Store word 0xFFFFFFFF to 0x21 after 0x20 holds 0x12345678.
  - Load 0x20 returns 0x12345678; misalign_o=1, err_addr_o=0x21.
  - A second bad store to 0x42 leaves err_addr_o=0x21.
  - err_clr_i pulse clears both flags.
- Range:
  - With DEPTH_WORDS=1024, load 0x1000 gives rd_data_o=0, range_err_o=1, err_addr_o=0x1000.
  - Store to 0x1000 does not alias into word 0.
- Collision:
  - Word 0x8 = 0x00000000; in one cycle, store byte 0x7F to 0x9 and load 0x8.
  - rd_data_o=0x00007F00 next cycle.
- Reset mid-load: rd_en_i in cycle N, rst_n low in N+1 gives rd_valid_o=0 and rd_data_o=0; all error flags are 0.
